// File: rtl/btn_sampler.sv
// btn_sampler
// Turns the clock divider's clk_fast square wave into single-cycle sample
// strobes in the master_clk domain. It then uses those strobes to debounce
// the raw push-buttons into a clean level, a press pulse and a release pulse
// for each button.
//
// clk_fast is only ever sampled as data. Every flop here is clocked by
// master_clk.
// STABLE_SAMPLES must be in 1..15, and 2**CW must be greater than
// STABLE_SAMPLES. This keeps the terminal count representable.

module btn_sampler #(
   parameter int NUM_BTNS       = 5,
   parameter int STABLE_SAMPLES = 4,
   parameter int CW             = 4
) (
   input  logic                master_clk,
   input  logic                rst,
   input  logic                clk_fast,
   input  logic [NUM_BTNS-1:0] btn_in,
   output logic                sample_tick,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic [NUM_BTNS-1:0] btn_press,
   output logic [NUM_BTNS-1:0] btn_release,
   output logic                any_press
);

   // A button's level flips on the tick where its counter already holds this
   // value and the synced input still disagrees with the level.
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

   logic                fast_s1;
   logic                fast_s2;
   logic                fast_p;
   logic                tick_cond;

   logic [NUM_BTNS-1:0] btn_s1;
   logic [NUM_BTNS-1:0] btn_s2;

   logic [CW-1:0]       cnt_q [NUM_BTNS];
   logic [CW-1:0]       cnt_d [NUM_BTNS];
   logic [NUM_BTNS-1:0] level_d;
   logic [NUM_BTNS-1:0] press_d;
   logic [NUM_BTNS-1:0] release_d;

   // Two-flop synchronizers for clk_fast and the buttons, plus the
   // previous-value flop used to find clk_fast rising edges.
   always_ff @(posedge master_clk or posedge rst) begin
      if (rst) begin
         fast_s1 <= 1'b0;
         fast_s2 <= 1'b0;
         fast_p  <= 1'b0;
         btn_s1  <= '0;
         btn_s2  <= '0;
      end else begin
         fast_s1 <= clk_fast;
         fast_s2 <= fast_s1;
         fast_p  <= fast_s2;
         btn_s1  <= btn_in;
         btn_s2  <= btn_s1;
      end
   end

   // Synced clk_fast is high and was low last cycle: this is a rising edge.
   assign tick_cond = fast_s2 & ~fast_p;

   // Per-button debounce decision. State only moves on tick cycles, so a
   // stopped clk_fast freezes every counter and level.
   always_comb begin
      level_d   = btn_level;
      press_d   = '0;
      release_d = '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      if (tick_cond) begin
         for (int i = 0; i < NUM_BTNS; i++) begin
            if (btn_s2[i] == btn_level[i]) begin
               // Agreement, including a bounce back, restarts the count.
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               level_d[i]   = ~btn_level[i];
               cnt_d[i]     = '0;
               press_d[i]   = btn_s2[i];
               release_d[i] = ~btn_s2[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // Register the tick, the debounce state and the pulses.
   // The pulses and any_press update on the same edge as btn_level.
   always_ff @(posedge master_clk or posedge rst) begin
      if (rst) begin
         sample_tick <= 1'b0;
         btn_level   <= '0;
         btn_press   <= '0;
         btn_release <= '0;
         any_press   <= 1'b0;
         for (int i = 0; i < NUM_BTNS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sample_tick <= tick_cond;
         btn_level   <= level_d;
         btn_press   <= press_d;
         btn_release <= release_d;
         any_press   <= |press_d;
         for (int i = 0; i < NUM_BTNS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule

// File: tb/tb_btn_sampler.sv
// Bench for btn_sampler. Each clk_fast rise pushes a scoreboard entry with
// the tick cycle and the post-tick outputs expected from a tick-level
// debounce model. The negedge monitor pops one entry for every sample_tick.

module tb_btn_sampler;

   localparam int NB = 5;
   localparam int SS = 4;

   typedef struct {
      int unsigned   cyc;
      logic [NB-1:0] level;
      logic [NB-1:0] press;
      logic [NB-1:0] rel;
      logic          any;
   } exp_t;

   logic          master_clk;
   logic          rst;
   logic          clk_fast;
   logic [NB-1:0] btn_in;
   logic          sample_tick;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;
   logic          any_press;

   int total = 0;
   int bad   = 0;

   int unsigned cyc = 0;
   exp_t        sb_q[$];
   logic [NB-1:0] m_level;
   int            m_cnt [NB];

   int ticks_seen = 0;
   int any_seen   = 0;
   int press_seen   [NB];
   int release_seen [NB];
   logic prev_tick = 1'b0;

   btn_sampler #(.NUM_BTNS(NB), .STABLE_SAMPLES(SS), .CW(4)) dut (
      .master_clk (master_clk),
      .rst        (rst),
      .clk_fast   (clk_fast),
      .btn_in     (btn_in),
      .sample_tick(sample_tick),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release),
      .any_press  (any_press)
   );

   initial master_clk = 1'b0;
   always #5 master_clk = ~master_clk;

   always @(posedge master_clk) cyc <= cyc + 1;

   // Scoreboard checker: every tick must match the oldest expected entry.
   // Pulses outside a tick cycle are errors.
   always @(negedge master_clk) begin
      if (!rst) begin
         if (sample_tick) begin
            ticks_seen++;
            total++;
            if (prev_tick) begin
               bad++;
               $display("FAIL tick_width: tick high on two consecutive cycles at cyc %0d", cyc);
            end
            if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_tick: got tick at cyc %0d, expected none", cyc);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               total++;
               if (cyc !== e.cyc) begin
                  bad++;
                  $display("FAIL tick_cycle: got cyc %0d, expected %0d", cyc, e.cyc);
               end
               total++;
               if ({btn_level, btn_press, btn_release, any_press} !==
                   {e.level, e.press, e.rel, e.any}) begin
                  bad++;
                  $display("FAIL tick_outputs: got lvl=%b prs=%b rel=%b any=%b, expected lvl=%b prs=%b rel=%b any=%b",
                           btn_level, btn_press, btn_release, any_press,
                           e.level, e.press, e.rel, e.any);
               end
            end
         end else if (btn_press !== '0 || btn_release !== '0 || any_press !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL stray_pulse: got prs=%b rel=%b any=%b without tick at cyc %0d",
                     btn_press, btn_release, any_press, cyc);
         end
         if (any_press === 1'b1) any_seen++;
         for (int i = 0; i < NB; i++) begin
            if (btn_press[i] === 1'b1) press_seen[i]++;
            if (btn_release[i] === 1'b1) release_seen[i]++;
         end
         prev_tick = sample_tick;
      end else begin
         prev_tick = 1'b0;
      end
   end

   // Tick-level debounce model, applied when the stimulus raises clk_fast.
   task automatic push_tick(input logic [NB-1:0] v);
      exp_t e;
      e.cyc   = cyc + 3;
      e.press = '0;
      e.rel   = '0;
      for (int i = 0; i < NB; i++) begin
         if (v[i] == m_level[i]) begin
            m_cnt[i] = 0;
         end else if (m_cnt[i] == SS - 1) begin
            m_level[i] = v[i];
            m_cnt[i]   = 0;
            if (v[i]) e.press[i] = 1'b1;
            else      e.rel[i]   = 1'b1;
         end else begin
            m_cnt[i] = m_cnt[i] + 1;
         end
      end
      e.level = m_level;
      e.any   = |e.press;
      sb_q.push_back(e);
   endtask

   task automatic model_reset();
      m_level = '0;
      for (int i = 0; i < NB; i++) m_cnt[i] = 0;
   endtask

   // Holds the buttons steady, then makes one full clk_fast period,
   // high for 5 cycles and low for 5 cycles.
   task automatic do_tick(input logic [NB-1:0] v);
      @(posedge master_clk); #1;
      btn_in = v;
      repeat (3) @(posedge master_clk);
      #1;
      clk_fast = 1'b1;
      push_tick(v);
      repeat (5) @(posedge master_clk);
      #1;
      clk_fast = 1'b0;
      repeat (5) @(posedge master_clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; clk_fast = 1'b0; btn_in = '0;
      model_reset();
      repeat (3) @(posedge master_clk);
      #1;
      total++;
      if ({sample_tick, btn_level, btn_press, btn_release, any_press} !== '0) begin
         bad++;
         $display("FAIL reset_state: got tick=%b lvl=%b prs=%b rel=%b any=%b, expected all 0",
                  sample_tick, btn_level, btn_press, btn_release, any_press);
      end
      rst = 1'b0;
      repeat (5) @(posedge master_clk);
      #1;
      total++;
      if ({sample_tick, btn_level, btn_press, btn_release, any_press} !== '0) begin
         bad++;
         $display("FAIL reset_release: got tick=%b lvl=%b prs=%b rel=%b any=%b, expected all 0",
                  sample_tick, btn_level, btn_press, btn_release, any_press);
      end
   endtask

   task automatic test_tick_gen();
      int t0;
      t0 = ticks_seen;
      btn_in = '0;
      for (int k = 0; k < 10; k++) begin
         @(posedge master_clk); #1;
         clk_fast = ~clk_fast;
         if (clk_fast) push_tick('0);
         repeat (9) @(posedge master_clk);
      end
      repeat (5) @(posedge master_clk);
      total++;
      if (ticks_seen - t0 !== 5) begin
         bad++;
         $display("FAIL tick_count: got %0d ticks, expected 5", ticks_seen - t0);
      end
   endtask

   task automatic test_clean_press();
      int p2, a0;
      p2 = press_seen[2]; a0 = any_seen;
      for (int k = 0; k < SS; k++) do_tick(5'b00100);
      total++;
      if (btn_level !== 5'b00100 || press_seen[2] - p2 !== 1 || any_seen - a0 !== 1) begin
         bad++;
         $display("FAIL clean_press: got lvl=%b press2=%0d any=%0d, expected lvl=00100 press2=1 any=1",
                  btn_level, press_seen[2] - p2, any_seen - a0);
      end
      for (int k = 0; k < SS; k++) do_tick('0);
   endtask

   task automatic test_bounce();
      int p0;
      p0 = press_seen[0];
      for (int k = 0; k < SS - 1; k++) do_tick(5'b00001);
      do_tick(5'b00000);
      for (int k = 0; k < SS - 1; k++) do_tick(5'b00001);
      total++;
      if (btn_level !== 5'b00000 || press_seen[0] - p0 !== 0) begin
         bad++;
         $display("FAIL bounce_early: got lvl=%b press0=%0d, expected lvl=00000 press0=0",
                  btn_level, press_seen[0] - p0);
      end
      do_tick(5'b00001);
      total++;
      if (btn_level !== 5'b00001 || press_seen[0] - p0 !== 1) begin
         bad++;
         $display("FAIL bounce_press: got lvl=%b press0=%0d, expected lvl=00001 press0=1",
                  btn_level, press_seen[0] - p0);
      end
   endtask

   task automatic test_release();
      int p0, r0;
      p0 = press_seen[0]; r0 = release_seen[0];
      for (int k = 0; k < SS; k++) do_tick('0);
      total++;
      if (btn_level !== 5'b00000 || release_seen[0] - r0 !== 1 || press_seen[0] - p0 !== 0) begin
         bad++;
         $display("FAIL release: got lvl=%b rel0=%0d press0=%0d, expected lvl=00000 rel0=1 press0=0",
                  btn_level, release_seen[0] - r0, press_seen[0] - p0);
      end
   endtask

   task automatic test_simultaneous();
      int a0;
      a0 = any_seen;
      for (int k = 0; k < SS; k++) do_tick(5'b10001);
      total++;
      if (btn_level !== 5'b10001 || any_seen - a0 !== 1) begin
         bad++;
         $display("FAIL simultaneous: got lvl=%b any_cycles=%0d, expected lvl=10001 any_cycles=1",
                  btn_level, any_seen - a0);
      end
      for (int k = 0; k < SS; k++) do_tick('0);
   endtask

   task automatic test_reset_mid_count();
      for (int k = 0; k < SS; k++) do_tick(5'b01000);
      do_tick(5'b01010);
      do_tick(5'b01010);
      @(negedge master_clk); #2;
      rst = 1'b1;
      #1;
      total++;
      if ({sample_tick, btn_level, btn_press, btn_release, any_press} !== '0) begin
         bad++;
         $display("FAIL async_reset: got tick=%b lvl=%b prs=%b rel=%b any=%b, expected all 0",
                  sample_tick, btn_level, btn_press, btn_release, any_press);
      end
      total++;
      if (sb_q.size() !== 0) begin
         bad++;
         $display("FAIL pending_at_reset: got %0d entries, expected 0", sb_q.size());
      end
      model_reset();
      repeat (2) @(posedge master_clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < SS - 1; k++) do_tick(5'b01010);
      total++;
      if (btn_level !== 5'b00000) begin
         bad++;
         $display("FAIL reset_discard: got lvl=%b, expected 00000", btn_level);
      end
      do_tick(5'b01010);
      total++;
      if (btn_level !== 5'b01010) begin
         bad++;
         $display("FAIL post_reset_press: got lvl=%b, expected 01010", btn_level);
      end
   endtask

   task automatic test_freeze();
      int t0, r1;
      do_tick(5'b01000);
      do_tick(5'b01000);
      t0 = ticks_seen; r1 = release_seen[1];
      for (int k = 0; k < 40; k++) begin
         @(posedge master_clk); #1;
         btn_in = NB'($urandom_range(0, 31));
      end
      repeat (4) @(posedge master_clk);
      total++;
      if (ticks_seen - t0 !== 0 || btn_level !== 5'b01010) begin
         bad++;
         $display("FAIL freeze: got ticks=%0d lvl=%b, expected ticks=0 lvl=01010",
                  ticks_seen - t0, btn_level);
      end
      do_tick(5'b01000);
      do_tick(5'b01000);
      total++;
      if (btn_level !== 5'b01000 || release_seen[1] - r1 !== 1) begin
         bad++;
         $display("FAIL freeze_resume: got lvl=%b rel1=%0d, expected lvl=01000 rel1=1",
                  btn_level, release_seen[1] - r1);
      end
      for (int k = 0; k < SS; k++) do_tick('0);
   endtask

   initial begin
      for (int i = 0; i < NB; i++) begin
         press_seen[i]   = 0;
         release_seen[i] = 0;
      end
      test_reset();
      test_tick_gen();
      test_clean_press();
      test_bounce();
      test_release();
      test_simultaneous();
      test_reset_mid_count();
      test_freeze();
      repeat (10) @(posedge master_clk);
      total++;
      if (sb_q.size() !== 0) begin
         bad++;
         $display("FAIL missing_ticks: got %0d unconsumed entries, expected 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/btn_sampler.md
Name: btn_sampler

Overview:
- Consumer end of the clock divider's slow outputs.
- Takes the divider's `clk_fast` square wave as a data input, never as a clock.
- Converts it into single-cycle sample strobes in the `master_clk` domain.
- Uses those strobes to debounce the raw game push-buttons into a clean level, a press pulse and a release pulse per button, for the whack-a-mole game FSM.

Parameters:
- NUM_BTNS, 5, number of independent push-buttons.
- STABLE_SAMPLES, 4, consecutive differing samples required before a button's level flips; legal range 1..15.
- CW, 4, per-button counter width; must satisfy 2^CW > STABLE_SAMPLES.

Ports:
- master_clk  input  1  sole clock; all flops on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- clk_fast  input  1  divided toggle signal from the clock divider; treated as asynchronous data.
- btn_in  input  NUM_BTNS  raw, bouncing, asynchronous buttons; active-high.
- sample_tick  output  1  one-cycle strobe per clk_fast rising edge.
- btn_level  output  NUM_BTNS  debounced button state.
- btn_press  output  NUM_BTNS  one-cycle pulse when the level goes 0->1.
- btn_release  output  NUM_BTNS  one-cycle pulse when the level goes 1->0.
- any_press  output  1  OR of btn_press, registered in the same cycle as btn_press (not delayed).

Behaviour:
- Reset (async assert, released synchronously to the design):
  - All outputs, synchronizer flops, edge-detect flop and counters go to 0.
  - No pulses are generated by reset assertion or deassertion.
- Synchronizers:
  - clk_fast and each btn_in bit pass through 2 flops (s1, s2) before any use.
  - clk_fast additionally has a previous-value flop p.
- Tick generation:
  - sample_tick <= s2 & ~p, registered.
  - Tick goes high on the 3rd master_clk edge after clk_fast rises and stays high exactly 1 cycle.
  - clk_fast falling edges produce no tick.
  - clk_fast held constant produces no ticks, so debounce state freezes.
- Per-button debounce (independent for every bit i). Evaluated only in cycles where the internal tick condition (s2 & ~p) is true; all other cycles hold state.
  - If synced btn == btn_level[i]: cnt[i] <= 0. Any bounce back restarts the count.
  - If synced btn != btn_level[i] and cnt[i] == STABLE_SAMPLES-1: btn_level[i] <= ~btn_level[i], cnt[i] <= 0, and the matching btn_press[i] or btn_release[i] pulses.
  - Otherwise: cnt[i] <= cnt[i] + 1.
- Pulse timing:
  - btn_press / btn_release assert on the same edge that btn_level changes and clear on the next edge.
  - They are therefore aligned with that cycle's sample_tick output.
- Edge cases:
  - STABLE_SAMPLES=1: the level follows the synced input at every tick.
  - The counter never exceeds STABLE_SAMPLES-1, so there is no wrap-around.
  - Simultaneous buttons are handled fully independently; any_press is high if at least one press pulses.
  - Button held through reset: after reset, level is 0 and the press is reported after STABLE_SAMPLES ticks.
  - Reset mid-count discards the partial count with no pulse.
  - A press and a release of the same button can never occur in the same cycle.

Test Plan:
- Tick generation: clk_fast toggled every 10 master_clk cycles for 100 cycles -> sample_tick pulses 5 times, each 1 cycle wide, 3 edges after each clk_fast rise; no pulse on falls.
- Clean press: btn_in[2]=1 held, STABLE_SAMPLES=4 -> btn_level[2] rises with the 4th tick after the synced input changes; btn_press[2] and any_press high exactly 1 cycle; other bits stay 0.
- Bounce rejection: btn_in[0] high for 3 ticks, low for 1 tick, high again -> no press until 4 further consecutive high ticks; exactly one btn_press[0] pulse overall.
- Release: after press, btn_in[0]=0 held -> btn_release[0] 1-cycle pulse on the 4th tick; btn_press stays 0.
- Simultaneous buttons: btn_in=5'b10001 applied at the same time -> btn_press=5'b10001 in one cycle; any_press=1 for 1 cycle.
- Async reset mid-count: rst pulsed for 2 cycles after 2 of 4 ticks with btn held -> all outputs 0 immediately without waiting for a clock edge; press appears 4 ticks after reset release; clk_fast stopped -> no tick, state frozen.
